cpu_operand_fetch: RTL and testbench
====================================

Name: cpu_operand_fetch

Overview:
Decode/operand-fetch stage sitting directly upstream of cpu_regs and downstream of instruction fetch. Decodes one RISC-16 instruction per cycle and drives the two register-file read addresses. Tracks in-flight destination writes in a per-register scoreboard, bypasses same-cycle writeback data, and stalls on RAW hazards. Issues a registered decoded task to execute over a valid/ready handshake.

Parameters:
REG_ADDR_WIDTH, 3, register index width (8 registers, r0 reads as zero).
REG_DATA_WIDTH, 16, data, instruction and PC width.
MAX_INFLIGHT, 3, maximum pending writes tracked per register; scoreboard counter width is clog2(MAX_INFLIGHT+1).

Ports:
clk_i  in  1  clock, all state on rising edge
rst_n_i  in  1  asynchronous, active-low reset
instr_valid_i  in  1  fetch presents an instruction
instr_i  in  16  instruction word
instr_pc_i  in  16  PC of instr_i
instr_ready_o  out  1  instruction accepted this cycle when high with instr_valid_i
rd_addr_o[1:0]  out  2x3  read addresses to cpu_regs
rd_data_i[1:0]  in  2x16  combinational read data from cpu_regs
wb_wr_en_i  in  1  writeback write strobe (same task that feeds cpu_regs)
wb_reg_addr_i  in  3  writeback register
wb_wr_data_i  in  16  writeback data
ex_valid_o  out  1  decoded task valid
ex_ready_i  in  1  execute accepts task
ex_opcode_o  out  3  opcode
ex_dst_o  out  3  destination register
ex_wr_en_o  out  1  task writes a register (dst != 0)
ex_op_a_o  out  16  operand A (value of rB)
ex_op_b_o  out  16  operand B (rC for ADD/NAND, rA otherwise)
ex_imm_o  out  16  extended immediate
ex_pc_o  out  16  instruction PC
hazard_o  out  1  current instruction blocked by scoreboard

Behaviour:
- Encoding: op[15:13], rA[12:10], rB[9:7], rC[2:0], imm7[6:0], imm10[9:0]. Opcodes: ADD 0, ADDI 1, NAND 2, LUI 3, SW 4, LW 5, BEQ 6, JALR 7.
- Reset: ex_valid_o=0, all ex_* data outputs 0, all scoreboard counters 0. instr_ready_o, hazard_o and rd_addr_o are combinational and follow from that state.
- rd_addr_o[0]=rB. rd_addr_o[1]=rC for ADD/NAND, else rA. Both addresses are driven combinationally from instr_i.
- Source use: port0 is used by all opcodes except LUI. Port1 is used by ADD, NAND, SW and BEQ.
- Destination: rA for ADD, ADDI, NAND, LUI, LW and JALR. The destination is marked only when rA != 0.
- Immediate: ADDI/SW/LW/BEQ sign-extend imm7. LUI gives {imm10, 6'b0}. ADD, NAND and JALR give 0.
- Operand value per used port:
  - address 0 -> 0.
  - Else, if wb_wr_en_i, wb_reg_addr_i == address and the counter == 1 -> wb_wr_data_i (bypass).
  - Else, if the counter == 0 -> rd_data_i.
  - Otherwise the port is hazarded.
- hazard_o is high when either port is hazarded, or when the destination counter == MAX_INFLIGHT and no writeback is retiring that register this cycle.
- instr_ready_o = !hazard_o && (!ex_valid_o || ex_ready_i). An instruction is accepted when instr_valid_i && instr_ready_o.
- On accept, all ex_* outputs are registered next edge and ex_valid_o=1. Latency is 1 cycle from accept to ex_valid_o.
- If ex_valid_o && !ex_ready_i, the ex_* outputs hold stable. If ex_ready_i and no accept, ex_valid_o clears.
- Scoreboard counter of register r, per edge:
  - +1 on accept with marked destination r.
  - -1 on wb_wr_en_i with wb_reg_addr_i == r, r != 0.
  - Both in the same cycle -> unchanged.
  - Decrement at 0 never occurs in legal operation; hold at 0.
- Writeback to r0 never changes any counter.
- Reset asserted mid-operation immediately clears ex_valid_o and all counters. No in-flight state survives.

Test Plan:
- Reset, then ADDI r1,r0,5 (0x2405) with ex_ready_i=1 -> next cycle ex_valid_o=1, op_a=0, imm=0x0005, dst=1, wr_en=1; counter[1]=1.
- ADD r2,r1,r1 immediately after with no writeback -> hazard_o=1, instr_ready_o=0. Then WB r1=0x0005 -> same cycle accepted, op_a=op_b=0x0005 via bypass.
- LUI r3,0x3FF -> imm=0xFFC0, no source hazard even if counter[rB]>0.
- ex_ready_i=0 for 3 cycles while ex_valid_o=1 -> ex_* outputs unchanged, instr_ready_o=0. Releasing ex_ready_i accepts the next instruction the same cycle.
- Issue 3 writes to r4 without writeback -> 4th write to r4 is stalled with hazard_o=1. A WB to r4 in that cycle allows accept; counter stays 3.
- Writes to r0 (ADDI r0,r0,7) -> no counter change, later reads of r0 give 0; reset mid-stall -> ex_valid_o=0 and all counters 0.

Source files
------------

// File: rtl/cpu_operand_fetch.sv
// RISC-16 decode / operand-fetch stage.
// Scoreboarded RAW stalls, writeback bypass, registered issue to execute.
module cpu_operand_fetch #(
  parameter int REG_ADDR_WIDTH = 3,
  parameter int REG_DATA_WIDTH = 16,
  parameter int MAX_INFLIGHT   = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 instr_valid_i,
  input  logic [REG_DATA_WIDTH-1:0]            instr_i,
  input  logic [REG_DATA_WIDTH-1:0]            instr_pc_i,
  output logic                                 instr_ready_o,
  output logic [1:0][REG_ADDR_WIDTH-1:0]       rd_addr_o,
  input  logic [1:0][REG_DATA_WIDTH-1:0]       rd_data_i,
  input  logic                                 wb_wr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0]            wb_reg_addr_i,
  input  logic [REG_DATA_WIDTH-1:0]            wb_wr_data_i,
  output logic                                 ex_valid_o,
  input  logic                                 ex_ready_i,
  output logic [2:0]                           ex_opcode_o,
  output logic [REG_ADDR_WIDTH-1:0]            ex_dst_o,
  output logic                                 ex_wr_en_o,
  output logic [REG_DATA_WIDTH-1:0]            ex_op_a_o,
  output logic [REG_DATA_WIDTH-1:0]            ex_op_b_o,
  output logic [REG_DATA_WIDTH-1:0]            ex_imm_o,
  output logic [REG_DATA_WIDTH-1:0]            ex_pc_o,
  output logic                                 hazard_o
);

  localparam int NREG = 1 << REG_ADDR_WIDTH;
  localparam int CW   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_MAX = CW'(MAX_INFLIGHT);

  typedef logic [REG_ADDR_WIDTH-1:0] addr_t;
  typedef logic [REG_DATA_WIDTH-1:0] data_t;

  logic [2:0] w_op;
  addr_t      w_ra, w_rb, w_rc;
  logic       w_add, w_addi, w_nand, w_lui;
  logic       w_sw, w_lw, w_beq, w_jalr;
  logic [1:0] w_use;
  logic [1:0] w_byp;
  logic [1:0] w_haz;
  data_t      w_val [2];
  logic       w_writes, w_dst_mark, w_dst_full;
  addr_t      w_dst;
  data_t      w_imm;
  logic       w_accept;
  logic [NREG-1:0] w_inc, w_dec;

  logic [CW-1:0] r_sb [NREG];
  logic          r_valid;
  logic [2:0]    r_opcode;
  addr_t         r_dst;
  logic          r_wr_en;
  data_t         r_op_a, r_op_b, r_imm, r_pc;

  assign w_op = instr_i[15:13];
  assign w_ra = instr_i[12:10];
  assign w_rb = instr_i[9:7];
  assign w_rc = instr_i[2:0];

  assign w_add  = (w_op == 3'd0);
  assign w_addi = (w_op == 3'd1);
  assign w_nand = (w_op == 3'd2);
  assign w_lui  = (w_op == 3'd3);
  assign w_sw   = (w_op == 3'd4);
  assign w_lw   = (w_op == 3'd5);
  assign w_beq  = (w_op == 3'd6);
  assign w_jalr = (w_op == 3'd7);

  assign rd_addr_o[0] = w_rb;
  assign rd_addr_o[1] = (w_add || w_nand) ? w_rc : w_ra;

  assign w_use[0] = !w_lui;
  assign w_use[1] = w_add || w_nand || w_sw || w_beq;

  always_comb begin
    w_imm = '0;
    unique case (1'b1)
      w_addi, w_sw, w_lw, w_beq:
        w_imm = {{(REG_DATA_WIDTH-7){instr_i[6]}}, instr_i[6:0]};
      w_lui:
        w_imm = {instr_i[9:0], {(REG_DATA_WIDTH-10){1'b0}}};
      default:
        w_imm = '0;
    endcase
  end

  // A pending count of 1 retiring this cycle is the only bypassable case.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_byp[p] = wb_wr_en_i && (wb_reg_addr_i == rd_addr_o[p])
               && (r_sb[rd_addr_o[p]] == C_ONE);
      w_haz[p] = w_use[p] && (rd_addr_o[p] != '0) && !w_byp[p]
               && (r_sb[rd_addr_o[p]] != '0);
      if (rd_addr_o[p] == '0)
        w_val[p] = '0;
      else if (w_byp[p])
        w_val[p] = wb_wr_data_i;
      else
        w_val[p] = rd_data_i[p];
    end
  end

  assign w_writes   = w_add || w_addi || w_nand || w_lui || w_lw || w_jalr;
  assign w_dst_mark = w_writes && (w_ra != '0);
  assign w_dst      = w_dst_mark ? w_ra : '0;
  assign w_dst_full = w_dst_mark && (r_sb[w_ra] == C_MAX)
                    && !(wb_wr_en_i && (wb_reg_addr_i == w_ra));

  assign hazard_o      = w_haz[0] || w_haz[1] || w_dst_full;
  assign instr_ready_o = !hazard_o && (!r_valid || ex_ready_i);
  assign w_accept      = instr_valid_i && instr_ready_o;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int r = 1; r < NREG; r++) begin
      w_inc[r] = w_accept && w_dst_mark && (w_ra == addr_t'(r));
      w_dec[r] = wb_wr_en_i && (wb_reg_addr_i == addr_t'(r));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < NREG; r++) r_sb[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_inc[r] && !w_dec[r])
          r_sb[r] <= r_sb[r] + C_ONE;
        else if (w_dec[r] && !w_inc[r] && r_sb[r] != '0)
          r_sb[r] <= r_sb[r] - C_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid  <= 1'b0;
      r_opcode <= '0;
      r_dst    <= '0;
      r_wr_en  <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_imm    <= '0;
      r_pc     <= '0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_opcode <= w_op;
      r_dst    <= w_dst;
      r_wr_en  <= w_dst_mark;
      r_op_a   <= w_val[0];
      r_op_b   <= w_val[1];
      r_imm    <= w_imm;
      r_pc     <= instr_pc_i;
    end else if (ex_ready_i) begin
      r_valid  <= 1'b0;
    end
  end

  assign ex_valid_o  = r_valid;
  assign ex_opcode_o = r_opcode;
  assign ex_dst_o    = r_dst;
  assign ex_wr_en_o  = r_wr_en;
  assign ex_op_a_o   = r_op_a;
  assign ex_op_b_o   = r_op_b;
  assign ex_imm_o    = r_imm;
  assign ex_pc_o     = r_pc;

endmodule

// File: tb/tb_cpu_operand_fetch.sv
// Directed bench for cpu_operand_fetch.
// Register file modelled as a fixed table; expectations hand-computed.
module tb_cpu_operand_fetch;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic             instr_valid_i;
  logic [15:0]      instr_i;
  logic [15:0]      instr_pc_i;
  logic             instr_ready_o;
  logic [1:0][2:0]  rd_addr_o;
  logic [1:0][15:0] rd_data_i;
  logic             wb_wr_en_i;
  logic [2:0]       wb_reg_addr_i;
  logic [15:0]      wb_wr_data_i;
  logic             ex_valid_o;
  logic             ex_ready_i;
  logic [2:0]       ex_opcode_o;
  logic [2:0]       ex_dst_o;
  logic             ex_wr_en_o;
  logic [15:0]      ex_op_a_o;
  logic [15:0]      ex_op_b_o;
  logic [15:0]      ex_imm_o;
  logic [15:0]      ex_pc_o;
  logic             hazard_o;

  logic [15:0] regs [8];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  always_comb begin
    for (int k = 0; k < 2; k++) rd_data_i[k] = regs[rd_addr_o[k]];
  end

  cpu_operand_fetch dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .instr_valid_i (instr_valid_i),
    .instr_i       (instr_i),
    .instr_pc_i    (instr_pc_i),
    .instr_ready_o (instr_ready_o),
    .rd_addr_o     (rd_addr_o),
    .rd_data_i     (rd_data_i),
    .wb_wr_en_i    (wb_wr_en_i),
    .wb_reg_addr_i (wb_reg_addr_i),
    .wb_wr_data_i  (wb_wr_data_i),
    .ex_valid_o    (ex_valid_o),
    .ex_ready_i    (ex_ready_i),
    .ex_opcode_o   (ex_opcode_o),
    .ex_dst_o      (ex_dst_o),
    .ex_wr_en_o    (ex_wr_en_o),
    .ex_op_a_o     (ex_op_a_o),
    .ex_op_b_o     (ex_op_b_o),
    .ex_imm_o      (ex_imm_o),
    .ex_pc_o       (ex_pc_o),
    .hazard_o      (hazard_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input logic [2:0] op, ra, rb, rc);
    return {op, ra, rb, 4'b0, rc};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] op, ra, rb,
                                        input logic [6:0] imm);
    return {op, ra, rb, imm};
  endfunction

  function automatic logic [15:0] enc_l(input logic [2:0] op, ra,
                                        input logic [9:0] imm);
    return {op, ra, imm};
  endfunction

  task automatic issue(input logic [15:0] ins, input logic [15:0] pc);
    instr_valid_i = 1'b1;
    instr_i       = ins;
    instr_pc_i    = pc;
  endtask

  task automatic wb(input logic [2:0] a, input logic [15:0] d);
    wb_wr_en_i    = 1'b1;
    wb_reg_addr_i = a;
    wb_wr_data_i  = d;
  endtask

  initial begin
    rst_n_i = 1'b0;
    instr_valid_i = 1'b0;
    instr_i = '0;
    instr_pc_i = '0;
    wb_wr_en_i = 1'b0;
    wb_reg_addr_i = '0;
    wb_wr_data_i = '0;
    ex_ready_i = 1'b1;
    regs[0] = 16'hBEEF;
    for (int i = 1; i < 8; i++) regs[i] = 16'h1000 + 16'(i);

    repeat (2) @(negedge clk_i);
    chk("rst_valid", ex_valid_o, 0);
    chk("rst_pc", ex_pc_o, 0);
    chk("rst_imm", ex_imm_o, 0);
    chk("rst_ready", instr_ready_o, 1);
    chk("rst_haz", hazard_o, 0);
    rst_n_i = 1'b1;

    issue(enc_i(3'd1, 3'd1, 3'd0, 7'd5), 16'h0010);
    #1 chk("addi_rdy", instr_ready_o, 1);
    chk("addi_rdaddr0", rd_addr_o[0], 0);
    @(negedge clk_i);
    chk("addi_valid", ex_valid_o, 1);
    chk("addi_opa", ex_op_a_o, 0);
    chk("addi_imm", ex_imm_o, 16'h0005);
    chk("addi_dst", ex_dst_o, 1);
    chk("addi_wren", ex_wr_en_o, 1);
    chk("addi_pc", ex_pc_o, 16'h0010);
    chk("addi_sb1", dut.r_sb[1], 1);

    issue(enc_r(3'd0, 3'd2, 3'd1, 3'd1), 16'h0012);
    #1 chk("raw_haz", hazard_o, 1);
    chk("raw_rdy", instr_ready_o, 0);
    @(negedge clk_i);
    chk("raw_drain", ex_valid_o, 0);
    chk("raw_sb1", dut.r_sb[1], 1);
    wb(3'd1, 16'h0005);
    #1 chk("byp_haz", hazard_o, 0);
    chk("byp_rdy", instr_ready_o, 1);
    @(negedge clk_i);
    wb_wr_en_i = 1'b0;
    chk("byp_valid", ex_valid_o, 1);
    chk("byp_opa", ex_op_a_o, 16'h0005);
    chk("byp_opb", ex_op_b_o, 16'h0005);
    chk("byp_dst", ex_dst_o, 2);
    chk("byp_pc", ex_pc_o, 16'h0012);
    chk("byp_sb1", dut.r_sb[1], 0);
    chk("byp_sb2", dut.r_sb[2], 1);

    issue(enc_l(3'd3, 3'd3, 10'h100), 16'h0014);
    #1 chk("lui_rdaddr0", rd_addr_o[0], 2);
    chk("lui_haz", hazard_o, 0);
    @(negedge clk_i);
    chk("lui1_imm", ex_imm_o, 16'h4000);
    chk("lui1_dst", ex_dst_o, 3);
    issue(enc_l(3'd3, 3'd3, 10'h3FF), 16'h0016);
    @(negedge clk_i);
    chk("lui2_imm", ex_imm_o, 16'hFFC0);
    chk("lui2_op", ex_opcode_o, 3);
    chk("lui2_sb3", dut.r_sb[3], 2);

    ex_ready_i = 1'b0;
    issue(enc_i(3'd1, 3'd5, 3'd0, 7'd1), 16'h0018);
    #1 chk("bp_rdy", instr_ready_o, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("bp_valid", ex_valid_o, 1);
      chk("bp_imm", ex_imm_o, 16'hFFC0);
      chk("bp_pc", ex_pc_o, 16'h0016);
      chk("bp_rdy_hold", instr_ready_o, 0);
    end
    ex_ready_i = 1'b1;
    #1 chk("rel_rdy", instr_ready_o, 1);
    @(negedge clk_i);
    chk("rel_imm", ex_imm_o, 16'h0001);
    chk("rel_dst", ex_dst_o, 5);
    chk("rel_pc", ex_pc_o, 16'h0018);

    issue(enc_i(3'd4, 3'd7, 3'd7, 7'h7F), 16'h001A);
    @(negedge clk_i);
    chk("sw_opa", ex_op_a_o, 16'h1007);
    chk("sw_opb", ex_op_b_o, 16'h1007);
    chk("sw_imm", ex_imm_o, 16'hFFFF);
    chk("sw_wren", ex_wr_en_o, 0);
    chk("sw_op", ex_opcode_o, 4);

    for (int k = 1; k <= 3; k++) begin
      issue(enc_i(3'd1, 3'd4, 3'd0, 7'(k)), 16'h001A + 16'(2 * k));
      @(negedge clk_i);
    end
    chk("full_sb4", dut.r_sb[4], 3);
    issue(enc_i(3'd1, 3'd4, 3'd0, 7'd4), 16'h0022);
    #1 chk("full_haz", hazard_o, 1);
    chk("full_rdy", instr_ready_o, 0);
    @(negedge clk_i);
    chk("full_drain", ex_valid_o, 0);
    wb(3'd4, 16'h0AAA);
    #1 chk("full_wb_haz", hazard_o, 0);
    chk("full_wb_rdy", instr_ready_o, 1);
    @(negedge clk_i);
    wb_wr_en_i = 1'b0;
    chk("full_valid", ex_valid_o, 1);
    chk("full_imm", ex_imm_o, 16'h0004);
    chk("full_sb4_hold", dut.r_sb[4], 3);

    issue(enc_i(3'd1, 3'd0, 3'd0, 7'd7), 16'h0024);
    @(negedge clk_i);
    instr_valid_i = 1'b0;
    chk("r0_wren", ex_wr_en_o, 0);
    chk("r0_dst", ex_dst_o, 0);
    chk("r0_sb0", dut.r_sb[0], 0);
    wb(3'd0, 16'h1234);
    @(negedge clk_i);
    wb_wr_en_i = 1'b0;
    chk("r0wb_sb0", dut.r_sb[0], 0);
    chk("r0wb_sb4", dut.r_sb[4], 3);

    issue(enc_r(3'd0, 3'd6, 3'd0, 3'd0), 16'h0026);
    @(negedge clk_i);
    chk("r0rd_opa", ex_op_a_o, 0);
    chk("r0rd_opb", ex_op_b_o, 0);
    chk("r0rd_dst", ex_dst_o, 6);

    issue(enc_r(3'd0, 3'd1, 3'd4, 3'd4), 16'h0028);
    #1 chk("mid_haz", hazard_o, 1);
    #1 rst_n_i = 1'b0;
    #1 chk("mid_valid", ex_valid_o, 0);
    chk("mid_sb4", dut.r_sb[4], 0);
    chk("mid_sb5", dut.r_sb[5], 0);
    chk("mid_sb6", dut.r_sb[6], 0);
    chk("mid_haz_clr", hazard_o, 0);
    instr_valid_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
